memory_dumper: RTL and testbench

//   Reads a contiguous range of ternary RAM after the CPU halts and streams each

---
 rtl/memory_dumper.sv | 134 +++++++++++++
 tb/tb_memory_dumper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/memory_dumper.sv
// memory_dumper: streams a contiguous range of ternary RAM out over valid/ready after CPU halt
module memory_dumper #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 9,
  parameter int CNT_W         = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_dump,
  input  logic [2*MEM_ADDR_SIZE-1:0] dump_base,
  input  logic [CNT_W-1:0]           dump_count,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                       mem_read,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic [2*WORD_SIZE-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       dump_complete
);
  localparam int AW = 2*MEM_ADDR_SIZE;
  localparam int DW = 2*WORD_SIZE;
  typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, DONE} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            mem_read_q, mem_read_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            busy_q, busy_d, done_q, done_d, start_hit;

  function automatic logic [AW-1:0] addr_norm(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) r[2*i+:2] = &a[2*i+:2] ? 2'b10 : a[2*i+:2];
    return r;
  endfunction

  function automatic logic [DW-1:0] data_norm(input logic [DW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < WORD_SIZE; i++) r[2*i+:2] = &a[2*i+:2] ? 2'b10 : a[2*i+:2];
    return r;
  endfunction

  // Ternary +1 with ripple carry; all-2s wraps silently to all-0s.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic c;
    r = a;
    c = 1'b1;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (c) begin
        r[2*i+:2] = a[2*i+:2] == 2'b00 ? 2'b01 : a[2*i+:2] == 2'b01 ? 2'b10 : 2'b00;
        c = a[2*i+1];
      end
    end
    return r;
  endfunction

  // Busy rises combinationally in the start cycle so even an empty dump shows one busy cycle.
  assign start_hit     = state_q == IDLE && start_dump;
  assign busy          = busy_q | start_hit;
  assign mem_addr      = mem_addr_q;
  assign mem_read      = mem_read_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign dump_complete = done_q;

  // Next-state and next-output logic; outputs are registered from the upcoming state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: if (start_dump) begin
        addr_d  = addr_norm(dump_base);
        cnt_d   = dump_count;
        busy_d  = dump_count != '0;
        state_d = dump_count == '0 ? DONE : READ;
      end
      READ: state_d = WAIT;
      WAIT: begin
        out_data_d  = data_norm(mem_read_data);
        out_valid_d = 1'b1;
        out_last_d  = cnt_q == CNT_W'(1);
        state_d     = HOLD;
      end
      HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        cnt_d       = cnt_q - CNT_W'(1);
        addr_d      = addr_inc(addr_q);
        busy_d      = !out_last_q;
        state_d     = out_last_q ? DONE : READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_read_d = state_d == READ;
    mem_addr_d = state_d == READ ? addr_d : mem_addr_q;
    done_d     = state_d == DONE;
  end

  // State and output registers with synchronous active-low reset that aborts any dump.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      mem_read_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      mem_read_q  <= mem_read_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_memory_dumper.sv
// tb_memory_dumper: directed scoreboard bench for memory_dumper
module tb_memory_dumper;
  logic        clock, reset, start_dump, mem_read, out_valid, out_ready, out_last, busy, dump_complete;
  logic [17:0] dump_base, mem_addr, mem_read_data, out_data;
  logic [15:0] dump_count;
  logic [17:0] exp_addr[$];
  logic [18:0] exp_word[$];
  int checks = 0, errors = 0, rd_cnt = 0, hs_cnt = 0, dc_cnt = 0, cyc = 0, last_hs_cyc = 0;
  logic        prev_stall = 0, prev_last = 0;
  logic [17:0] prev_data = 0;

  memory_dumper dut (
    .clock(clock), .reset(reset), .start_dump(start_dump), .dump_base(dump_base),
    .dump_count(dump_count), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .dump_complete(dump_complete)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [17:0] to_tern(input int v);
    logic [17:0] r;
    int x;
    x = v;
    for (int i = 0; i < 9; i++) begin
      r[2*i+:2] = 2'(x % 3);
      x = x / 3;
    end
    return r;
  endfunction

  function automatic logic [17:0] ram_word(input logic [17:0] a);
    return {a[1:0], a[17:2]};
  endfunction

  always @(posedge clock) if (mem_read) mem_read_data <= ram_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: reads and handshakes are matched against the expectation queues.
  always @(negedge clock) begin
    logic [18:0] w;
    #2;
    if (!reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
        chk("hold_noread", mem_read, 0);
      end
      if (mem_read) begin
        rd_cnt++;
        chk("read_pending", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) chk("read_addr", mem_addr, exp_addr.pop_front());
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        chk("word_pending", exp_word.size() != 0, 1);
        if (exp_word.size() != 0) begin
          w = exp_word.pop_front();
          chk("out_data", out_data, w[17:0]);
          chk("out_last", out_last, w[18]);
        end
      end
      if (dump_complete) dc_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic push_exp(input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      exp_addr.push_back(to_tern((base + k) % 19683));
      exp_word.push_back({k == cnt - 1, ram_word(to_tern((base + k) % 19683))});
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_read"}, mem_read, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, dump_complete, 0);
  endtask

  task automatic run_dump(input int base, input int cnt, input int stall);
    int hs0, rd0, dc0, c;
    bit stalled;
    hs0 = hs_cnt; rd0 = rd_cnt; dc0 = dc_cnt; stalled = 0; c = 0;
    push_exp(base, cnt);
    start_dump = 1; dump_base = to_tern(base); dump_count = 16'(cnt);
    #1 chk("busy_start", busy, 1);
    @(negedge clock);
    start_dump = 0; dump_base = 18'($urandom); dump_count = 16'($urandom);
    #1;
    if (cnt == 0) begin
      chk("zero_read", mem_read, 0);
      chk("zero_done", dump_complete, 1);
      chk("zero_busy", busy, 0);
      chk("zero_valid", out_valid, 0);
    end else begin
      chk("lat_read", mem_read, 1);
      chk("busy_run", busy, 1);
      @(negedge clock); #1 chk("lat_valid2", out_valid, 0);
      @(negedge clock); #1 chk("lat_valid3", out_valid, 1);
      while (!dump_complete && c < 200) begin
        if (stall >= 0 && !stalled && out_valid && hs_cnt - hs0 == stall) begin
          out_ready = 0;
          repeat (5) @(negedge clock);
          out_ready = 1;
          stalled = 1;
        end else begin
          @(negedge clock); #1;
        end
        c++;
      end
      chk("done_seen", dump_complete, 1);
      chk("done_busy", busy, 0);
      chk("done_gap", cyc - last_hs_cyc, 1);
    end
    @(negedge clock); #1;
    chk("done_pulse", dump_complete, 0);
    chk("done_count", dc_cnt - dc0, 1);
    chk("read_count", rd_cnt - rd0, cnt);
    chk("word_count", hs_cnt - hs0, cnt);
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("word_q_empty", exp_word.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd0, dc0;
    reset = 0; start_dump = 0; dump_base = 0; dump_count = 0; out_ready = 1;
    repeat (3) @(negedge clock);
    #1 check_idle_zero("reset");
    reset = 1;
    @(negedge clock); #1;
    run_dump(0, 3, -1);
    run_dump(5, 2, -1);
    run_dump(19682, 2, -1);
    run_dump(4, 0, -1);
    run_dump(20, 4, 1);
    rd0 = rd_cnt; dc0 = dc_cnt;
    push_exp(10, 4);
    start_dump = 1; dump_base = to_tern(10); dump_count = 4;
    @(negedge clock); #1;
    start_dump = 0; out_ready = 0;
    repeat (2) @(negedge clock);
    #1 chk("abort_hold", out_valid, 1);
    start_dump = 1; dump_base = to_tern(100); dump_count = 1;
    @(negedge clock); #1;
    start_dump = 0;
    chk("ignore_valid", out_valid, 1);
    chk("ignore_busy", busy, 1);
    @(negedge clock); #1 chk("ignore_reads", rd_cnt - rd0, 1);
    reset = 0;
    @(negedge clock); #1 check_idle_zero("abort");
    reset = 1; out_ready = 1;
    exp_addr.delete(); exp_word.delete();
    repeat (3) @(negedge clock);
    #1;
    chk("abort_no_done", dc_cnt - dc0, 0);
    chk("abort_idle_valid", out_valid, 0);
    run_dump(7, 2, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
